page_req_arb: RTL

Shares one free-list page-allocation port among several packet allocators. Each allocator issues single-cycle page requests and receives page numbers back in request order. The block arbitrates requests round-robin onto the free list and records the winner of each grant in an in-order tag FIFO. It then steers each free-list response back to the requester that owns it. It sits between the allocator array and the linked-list free-page manager.

---
 rtl/page_req_arb.sv | 114 +++++++++++
 1 files changed

// File: rtl/page_req_arb.sv
// Round-robin arbiter sharing one free-list page-allocation port among several
// requesters; an in-order tag FIFO steers each returned page to its owner.
module page_req_arb #(
  parameter int reqs  = 4,
  parameter int asz   = 8,
  parameter int depth = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [reqs-1:0]            par_srdy,
  output logic [reqs-1:0]            par_drdy,
  output logic [reqs-1:0]            parr_srdy,
  input  logic [reqs-1:0]            parr_drdy,
  output logic [asz-1:0]             parr_page,
  output logic                       flr_srdy,
  input  logic                       flr_drdy,
  input  logic                       fls_srdy,
  output logic                       fls_drdy,
  input  logic [asz-1:0]             fls_page,
  output logic [$clog2(depth+1)-1:0] ostd_cnt,
  output logic                       err
);

  localparam int unsigned NR = reqs;
  localparam int PW = (reqs > 1) ? $clog2(reqs) : 1;
  localparam int AW = $clog2(depth);
  localparam int CW = $clog2(depth + 1);

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] g;
  logic [PW-1:0] tag_head;
  logic [PW-1:0] tag_mem [depth];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          err_q;
  logic          full;
  logic          empty;
  logic          any_req;
  logic          push;
  logic          pop;

  assign full     = (cnt == CW'(depth));
  assign empty    = (cnt == '0);
  assign any_req  = |par_srdy;
  assign tag_head = tag_mem[rd_ptr];

  // First active requester at or above rr_ptr, wrapping modulo reqs.
  always_comb begin
    logic        found;
    int unsigned idx;
    g     = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < NR; i++) begin
      idx = (32'(rr_ptr) + i) % NR;
      if (!found && par_srdy[idx]) begin
        g     = PW'(idx);
        found = 1'b1;
      end
    end
  end

  assign flr_srdy = !reset && any_req && !full;
  assign push     = flr_srdy && flr_drdy;

  always_comb begin
    par_drdy = '0;
    if (!reset && any_req && flr_drdy && !full)
      par_drdy[g] = 1'b1;
  end

  always_comb begin
    parr_srdy = '0;
    if (!reset && fls_srdy && !empty)
      parr_srdy[tag_head] = 1'b1;
  end

  assign fls_drdy  = !reset && !empty && parr_drdy[tag_head];
  assign pop       = fls_srdy && fls_drdy;
  assign parr_page = fls_page;
  assign ostd_cnt  = cnt;
  assign err       = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      err_q  <= 1'b0;
    end else begin
      if (push) begin
        rr_ptr <= (g == PW'(reqs - 1)) ? '0 : g + 1'b1;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        cnt <= cnt + 1'b1;
      else if (pop && !push)
        cnt <= cnt - 1'b1;
      if (fls_srdy && empty)
        err_q <= 1'b1;
    end
  end

  // Tag storage needs no reset: push is held low while reset is asserted.
  always_ff @(posedge clk) begin
    if (push)
      tag_mem[wr_ptr] <= g;
  end

endmodule
